mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Memory-access stage plus MEM/WB pipeline register. It consumes the EX/MEM register outputs, performs load and store accesses on a local word-addressed data memory, and resolves the branch decision. Slow reads stall the pipeline through a wait-state FSM. It registers everything write-back needs into the MEM/WB boundary.

Parameters:
ADDR_W, 8, word-address width; memory holds 2**ADDR_W 32-bit words
RD_WAIT, 1, extra stall cycles per load (0..15); 0 = no stall

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
inReg2  in  1  RegWrite control from EX/MEM
inMemReg2  in  1  MemToReg control from EX/MEM
inMemW2  in  1  store request
inMemR2  in  1  load request
inBranch2  in  1  branch instruction flag
inZFlag  in  1  ALU zero flag
inBranchRes  in  32  branch target address
inALURes1  in  32  ALU result / byte address
inDR2V  in  32  store data (rs2 value)
inRegMux1  in  5  destination register
outPCSrc  out  1  branch taken, combinational
outBranchTarget  out  32  = inBranchRes, combinational
outStall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle, combinational
outReg3  out  1  RegWrite to WB, registered
outMemReg3  out  1  MemToReg to WB, registered
outReadData  out  32  load data, registered
outALURes2  out  32  ALU result to WB, registered
outRegMux2  out  5  destination register to WB, registered
outMisalign  out  1  misaligned-access flag for the instruction in MEM/WB, registered

Behaviour:
- Reset (rst_n=0, async): FSM IDLE, wait counter 0, all registered outputs 0. Memory array is not reset.
- Address: word index = inALURes1[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap. aligned = (inALURes1[1:0]==0).
- Decode:
  - wr = inMemW2 & aligned.
  - rd = inMemR2 & ~inMemW2 & aligned.
  - If both MemW and MemR are high, the access is a store only.
- Store: when wr in IDLE, the word is written at the posedge; no stall.
- Load with RD_WAIT=0: array read is combinational; the data is captured into outReadData on the same posedge; no stall.
- Load FSM with RD_WAIT=N>0:
  - IDLE & rd: outStall=1. Next state WAIT, cnt=N-1.
  - WAIT & cnt!=0: outStall=1, cnt decrements.
  - WAIT & cnt==0: outStall=0. MEM/WB captures the load. Next state IDLE.
  - Net effect: a load occupies N+1 cycles with N stall cycles.
- Upstream holds EX/MEM inputs stable while outStall=1. Input changes during WAIT are not tracked.
- MEM/WB capture on every posedge:
  - If outStall=1, a bubble is loaded: outReg3=0, outMemReg3=0, outMisalign=0, other registered outputs 0.
  - Otherwise outputs load from the current inputs; outReadData = memory word if rd, else 0.
- Misaligned access (MemR|MemW with inALURes1[1:0]!=0):
  - No memory access, no stall.
  - outMisalign=1 for that instruction.
  - For a misaligned load, outReg3 is forced 0 and outReadData=0.
  - A misaligned store leaves memory unchanged.
- Branch: outPCSrc = inBranch2 & inZFlag, independent of FSM state.
- Store followed by load to the same address: the load returns the new data, because the write lands before the next cycle's read.
- Reset asserted mid-WAIT: immediately IDLE, outStall=0, outputs 0. The interrupted load is dropped.

Test Plan:
- Reset then store: rst_n low 2 cycles → all outputs 0. Store 0xDEADBEEF at addr 0x10, then load addr 0x10 with RD_WAIT=1 → outStall=1 for exactly 1 cycle; next posedge outReadData=0xDEADBEEF, outReg3=1, outMemReg3=1, outRegMux2=inRegMux1.
- RD_WAIT=3 load: outStall high 3 consecutive cycles, MEM/WB shows a bubble (outReg3=0) during those 3 posedges, data valid on the 4th.
- Misaligned load at 0x13 with inReg2=1 → no stall, outMisalign=1, outReg3=0, outReadData=0. Misaligned store at 0x22 → a following load of 0x20 returns the prior contents.
- Branch: inBranch2=1, inZFlag=1, inBranchRes=0x40 → outPCSrc=1, outBranchTarget=0x40 same cycle. inZFlag=0 → outPCSrc=0.
- Simultaneous MemW=MemR=1 at 0x8 with data 0x55 → no stall, a later load of 0x8 returns 0x55. Wrap: with ADDR_W=8, address 0x404 aliases 0x004.
- Reset asserted during WAIT (RD_WAIT=3, after 1 stall cycle) → outStall drops immediately, FSM IDLE, outputs 0. A subsequent ALU-only instruction passes through normally (outALURes2 = its result on the next posedge).

Source files
------------

// File: rtl/mem_wb_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Memory-access stage with local word-addressed data memory,
//                branch resolution, load wait-state FSM and MEM/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int ADDR_W  = 8,   // word-address width, 2**ADDR_W words
    parameter int RD_WAIT = 1    // extra stall cycles per load (0..15)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inReg2,
    input  logic        inMemReg2,
    input  logic        inMemW2,
    input  logic        inMemR2,
    input  logic        inBranch2,
    input  logic        inZFlag,
    input  logic [31:0] inBranchRes,
    input  logic [31:0] inALURes1,
    input  logic [31:0] inDR2V,
    input  logic [4:0]  inRegMux1,
    output logic        outPCSrc,
    output logic [31:0] outBranchTarget,
    output logic        outStall,
    output logic        outReg3,
    output logic        outMemReg3,
    output logic [31:0] outReadData,
    output logic [31:0] outALURes2,
    output logic [4:0]  outRegMux2,
    output logic        outMisalign
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    // Data memory; deliberately not reset.
    logic [31:0]       r_mem [c_DEPTH];

    logic              w_aligned;
    logic              w_access;
    logic              w_misalign;
    logic              w_mis_load;
    logic              w_wr;
    logic              w_rd;
    logic              w_stall;
    logic              w_idle;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_rdata;

    // ------------------------------------------------------------------------
    // Address decode. Bits above the word index are dropped, so addresses wrap.
    // ------------------------------------------------------------------------
    assign w_idx      = inALURes1[ADDR_W+1:2];
    assign w_aligned  = (inALURes1[1:0] == 2'b00);
    assign w_access   = inMemR2 | inMemW2;
    assign w_misalign = w_access & ~w_aligned;

    // A request carrying both MemW and MemR behaves as a store only.
    assign w_wr       = inMemW2 & w_aligned;
    assign w_rd       = inMemR2 & ~inMemW2 & w_aligned;

    // A misaligned load must not write back a register.
    assign w_mis_load = w_misalign & inMemR2 & ~inMemW2;

    // Asynchronous array read; the MEM/WB register provides the pipelining.
    assign w_rdata    = r_mem[w_idx];

    // ------------------------------------------------------------------------
    // Branch resolution is purely combinational and ignores stall state.
    // ------------------------------------------------------------------------
    assign outPCSrc        = inBranch2 & inZFlag;
    assign outBranchTarget = inBranchRes;
    assign outStall        = w_stall;

    // ------------------------------------------------------------------------
    // Load wait-state sequencing.
    // ------------------------------------------------------------------------
    generate
        if (RD_WAIT == 0) begin : g_no_wait
            // Single-cycle memory: loads never stall, FSM is permanently idle.
            assign w_stall = 1'b0;
            assign w_idle  = 1'b1;
        end else begin : g_wait_fsm
            typedef enum logic [0:0] {
                S_IDLE = 1'b0,
                S_WAIT = 1'b1
            } state_t;

            // First stall cycle happens in IDLE, so WAIT counts the rest.
            localparam logic [3:0] c_CNT_INIT = 4'(RD_WAIT - 1);

            state_t     r_state;
            logic [3:0] r_cnt;

            // Wait-state FSM: IDLE accepts a load, WAIT counts out the latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_rd) begin
                                r_state <= S_WAIT;
                                r_cnt   <= c_CNT_INIT;
                            end
                        end
                        S_WAIT: begin
                            if (r_cnt != 4'd0) begin
                                r_cnt <= r_cnt - 4'd1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_cnt   <= 4'd0;
                        end
                    endcase
                end
            end

            // Stall while a load is entering or still counting; never during reset.
            assign w_stall = rst_n & (((r_state == S_IDLE) & w_rd) |
                                      ((r_state == S_WAIT) & (r_cnt != 4'd0)));
            assign w_idle  = (r_state == S_IDLE);
        end
    endgenerate

    // Store port: aligned stores commit at the edge when the FSM is idle.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr && w_idle) begin
            r_mem[w_idx] <= inDR2V;
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outReg3     <= 1'b0;
            outMemReg3  <= 1'b0;
            outReadData <= 32'd0;
            outALURes2  <= 32'd0;
            outRegMux2  <= 5'd0;
            outMisalign <= 1'b0;
        end else if (w_stall) begin
            outReg3     <= 1'b0;
            outMemReg3  <= 1'b0;
            outReadData <= 32'd0;
            outALURes2  <= 32'd0;
            outRegMux2  <= 5'd0;
            outMisalign <= 1'b0;
        end else begin
            outReg3     <= inReg2 & ~w_mis_load;
            outMemReg3  <= inMemReg2;
            outReadData <= w_rd ? w_rdata : 32'd0;
            outALURes2  <= inALURes1;
            outRegMux2  <= inRegMux1;
            outMisalign <= w_misalign;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Self-checking bench for mem_wb_stage with RD_WAIT = 0, 1, 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    typedef struct packed {
        logic        reg2;
        logic        memreg2;
        logic        memw;
        logic        memr;
        logic        br;
        logic        z;
        logic [31:0] bres;
        logic [31:0] alu;
        logic [31:0] dr;
        logic [4:0]  rmux;
    } in_t;

    typedef struct packed {
        logic        pcsrc;
        logic [31:0] btgt;
        logic        stall;
        logic        reg3;
        logic        memreg3;
        logic [31:0] rdata;
        logic [31:0] alu2;
        logic [4:0]  rmux2;
        logic        mis;
    } out_t;

    typedef struct {
        in_t  x;
        out_t e;
        int   nstall;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    in_t         din  [3];
    out_t        dout [3];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mm [3][256];
    int          rw [3] = '{0, 1, 3};
    vec_t        tbl [12];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic        w_pcsrc, w_stall, w_reg3, w_memreg3, w_mis;
        logic [31:0] w_btgt, w_rdata, w_alu2;
        logic [4:0]  w_rmux2;

        mem_wb_stage #(
            .ADDR_W (8),
            .RD_WAIT((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .inReg2         (din[g].reg2),
            .inMemReg2      (din[g].memreg2),
            .inMemW2        (din[g].memw),
            .inMemR2        (din[g].memr),
            .inBranch2      (din[g].br),
            .inZFlag        (din[g].z),
            .inBranchRes    (din[g].bres),
            .inALURes1      (din[g].alu),
            .inDR2V         (din[g].dr),
            .inRegMux1      (din[g].rmux),
            .outPCSrc       (w_pcsrc),
            .outBranchTarget(w_btgt),
            .outStall       (w_stall),
            .outReg3        (w_reg3),
            .outMemReg3     (w_memreg3),
            .outReadData    (w_rdata),
            .outALURes2     (w_alu2),
            .outRegMux2     (w_rmux2),
            .outMisalign    (w_mis)
        );

        assign dout[g] = {w_pcsrc, w_btgt, w_stall, w_reg3, w_memreg3,
                          w_rdata, w_alu2, w_rmux2, w_mis};
    end

    task automatic chk(input int k, input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (dut%0d, t=%0t): got %h, expected %h", nm, k, $time, got, exp);
        end
    endtask

    // Issue one instruction to instance k, hold it through nstall stall cycles,
    // then check the MEM/WB contents after the capturing edge.
    task automatic apply(input int k, input in_t x, input out_t e, input int nstall);
        @(negedge clk);
        din[k] = x;
        #1;
        chk(k, "pcsrc", 32'(dout[k].pcsrc), 32'(e.pcsrc));
        chk(k, "btgt",  dout[k].btgt, e.btgt);
        for (int i = 0; i < nstall; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            chk(k, "stall_hi", 32'(dout[k].stall), 32'd1);
            @(posedge clk);
            #1;
            chk(k, "bubble_ctl", 32'({dout[k].reg3, dout[k].memreg3, dout[k].mis, dout[k].rmux2}), 32'd0);
            chk(k, "bubble_data", dout[k].rdata | dout[k].alu2, 32'd0);
        end
        if (nstall > 0) begin
            @(negedge clk);
            #1;
        end
        chk(k, "stall_lo", 32'(dout[k].stall), 32'd0);
        @(posedge clk);
        #1;
        chk(k, "reg3",    32'(dout[k].reg3),    32'(e.reg3));
        chk(k, "memreg3", 32'(dout[k].memreg3), 32'(e.memreg3));
        chk(k, "rdata",   dout[k].rdata,        e.rdata);
        chk(k, "alu2",    dout[k].alu2,         e.alu2);
        chk(k, "rmux2",   32'(dout[k].rmux2),   32'(e.rmux2));
        chk(k, "mis",     32'(dout[k].mis),     32'(e.mis));
        din[k] = '0;
    endtask

    // Transaction-level reference: one instruction in, write-back record out.
    task automatic model_step(input int k, input in_t x, output out_t e, output int nstall);
        bit mis, rd, wr;
        int idx;
        mis = (x.memr || x.memw) && (x.alu % 4 != 0);
        wr  = x.memw && !mis;
        rd  = x.memr && !x.memw && !mis;
        idx = int'((x.alu / 4) % 256);
        e         = '0;
        e.pcsrc   = x.br && x.z;
        e.btgt    = x.bres;
        e.reg3    = x.reg2 && !(mis && x.memr && !x.memw);
        e.memreg3 = x.memreg2;
        e.rdata   = rd ? mm[k][idx] : 32'd0;
        e.alu2    = x.alu;
        e.rmux2   = x.rmux;
        e.mis     = mis;
        nstall    = rd ? rw[k] : 0;
        if (wr) mm[k][idx] = x.dr;
    endtask

    function automatic in_t rand_instr();
        in_t x;
        int  sel;
        x         = '0;
        x.reg2    = 1'($urandom);
        x.memreg2 = 1'($urandom);
        x.br      = 1'($urandom);
        x.z       = 1'($urandom);
        x.bres    = $urandom;
        x.alu     = $urandom;
        x.dr      = $urandom;
        x.rmux    = 5'($urandom);
        sel       = $urandom_range(0, 99);
        if (sel < 40) begin
            x.memr = 1'b1;  x.alu[1:0] = 2'b00;
        end else if (sel < 65) begin
            x.memw = 1'b1;  x.alu[1:0] = 2'b00;
        end else if (sel < 75) begin
            x.memr = 1'b1;  x.memw = 1'b1;  x.alu[1:0] = 2'b00;
        end else if (sel < 85) begin
            x.memr = 1'($urandom);
            x.memw = ~x.memr;
            x.alu[1:0] = 2'($urandom_range(1, 3));
        end
        return x;
    endfunction

    function automatic vec_t mkv(
        input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
        input logic rg, input logic mr, input logic [4:0] rm,
        input logic b, input logic z, input logic [31:0] bt,
        input logic e_pc, input logic e_reg3, input logic e_mr3,
        input logic [31:0] e_rd, input logic e_mis, input int ns);
        vec_t v;
        v.x         = '0;
        v.x.memw    = w;   v.x.memr    = r;  v.x.alu  = a;  v.x.dr = d;
        v.x.reg2    = rg;  v.x.memreg2 = mr; v.x.rmux = rm;
        v.x.br      = b;   v.x.z       = z;  v.x.bres = bt;
        v.e         = '0;
        v.e.pcsrc   = e_pc;  v.e.btgt    = bt;    v.e.reg3  = e_reg3;
        v.e.memreg3 = e_mr3; v.e.rdata   = e_rd;  v.e.alu2  = a;
        v.e.rmux2   = rm;    v.e.mis     = e_mis;
        v.nstall    = ns;
        return v;
    endfunction

    initial begin
        in_t  x;
        out_t e;
        int   ns;

        for (int k = 0; k < 3; k++) din[k] = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk(k, "rst_ctl", 32'({dout[k].reg3, dout[k].memreg3, dout[k].mis,
                                   dout[k].stall, dout[k].pcsrc}), 32'd0);
            chk(k, "rst_data", dout[k].rdata | dout[k].alu2 | 32'(dout[k].rmux2), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors on the RD_WAIT=1 instance
        //          w  r  addr          data          rg mr rm  b  z  btgt    pc rg3 mr3 rdata         mis ns
        tbl[0]  = mkv(1, 0, 32'h10,  32'hDEADBEEF, 0, 0, 0,  0, 0, 32'h0,  0, 0, 0, 32'h0,        0, 0);
        tbl[1]  = mkv(0, 1, 32'h10,  32'h0,        1, 1, 5,  0, 0, 32'h0,  0, 1, 1, 32'hDEADBEEF, 0, 1);
        tbl[2]  = mkv(0, 1, 32'h13,  32'h0,        1, 1, 6,  0, 0, 32'h0,  0, 0, 1, 32'h0,        1, 0);
        tbl[3]  = mkv(1, 0, 32'h20,  32'h11111111, 0, 0, 0,  0, 0, 32'h0,  0, 0, 0, 32'h0,        0, 0);
        tbl[4]  = mkv(1, 0, 32'h22,  32'h22222222, 0, 0, 0,  0, 0, 32'h0,  0, 0, 0, 32'h0,        1, 0);
        tbl[5]  = mkv(0, 1, 32'h20,  32'h0,        1, 1, 7,  0, 0, 32'h0,  0, 1, 1, 32'h11111111, 0, 1);
        tbl[6]  = mkv(0, 0, 32'h7,   32'h0,        1, 0, 3,  1, 1, 32'h40, 1, 1, 0, 32'h0,        0, 0);
        tbl[7]  = mkv(0, 0, 32'h7,   32'h0,        0, 0, 3,  1, 0, 32'h40, 0, 0, 0, 32'h0,        0, 0);
        tbl[8]  = mkv(1, 1, 32'h8,   32'h55,       0, 1, 0,  0, 0, 32'h0,  0, 0, 1, 32'h0,        0, 0);
        tbl[9]  = mkv(0, 1, 32'h8,   32'h0,        1, 1, 9,  1, 1, 32'h99, 1, 1, 1, 32'h55,       0, 1);
        tbl[10] = mkv(1, 0, 32'h404, 32'hCAFEF00D, 0, 0, 0,  0, 0, 32'h0,  0, 0, 0, 32'h0,        0, 0);
        tbl[11] = mkv(0, 1, 32'h004, 32'h0,        1, 0, 1,  0, 0, 32'h0,  0, 1, 0, 32'hCAFEF00D, 0, 1);
        for (int i = 0; i < 12; i++) apply(1, tbl[i].x, tbl[i].e, tbl[i].nstall);

        // RD_WAIT=3: three stall cycles with bubbles, data on the fourth edge
        x = '0; x.memw = 1'b1; x.alu = 32'h30; x.dr = 32'hA5A50001;
        e = '0; e.alu2 = 32'h30;
        apply(2, x, e, 0);
        x = '0; x.memr = 1'b1; x.alu = 32'h30; x.reg2 = 1'b1; x.memreg2 = 1'b1; x.rmux = 5'd12;
        e = '0; e.alu2 = 32'h30; e.reg3 = 1'b1; e.memreg3 = 1'b1; e.rmux2 = 5'd12; e.rdata = 32'hA5A50001;
        apply(2, x, e, 3);

        // Reset asserted in the middle of a RD_WAIT=3 load
        @(negedge clk);
        x = '0; x.memr = 1'b1; x.alu = 32'h30; x.reg2 = 1'b1; x.rmux = 5'd4;
        din[2] = x;
        #1;
        chk(2, "rstw_stall0", 32'(dout[2].stall), 32'd1);
        @(posedge clk);
        #1;
        chk(2, "rstw_bubble", 32'(dout[2].reg3), 32'd0);
        @(negedge clk);
        #1;
        chk(2, "rstw_stall1", 32'(dout[2].stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk(2, "rstw_drop", 32'(dout[2].stall), 32'd0);
        chk(2, "rstw_out", dout[2].rdata | dout[2].alu2 | 32'({dout[2].reg3, dout[2].rmux2}), 32'd0);
        @(posedge clk);
        #1;
        chk(2, "rstw_hold", 32'(dout[2].stall), 32'd0);
        din[2] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        x = '0; x.alu = 32'h1234; x.reg2 = 1'b1; x.rmux = 5'd2;
        e = '0; e.alu2 = 32'h1234; e.reg3 = 1'b1; e.rmux2 = 5'd2;
        apply(2, x, e, 0);

        // Fill every word of every instance so random loads read known data
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 256; i++) begin
                x = '0; x.memw = 1'b1; x.alu = 32'(i * 4); x.dr = $urandom;
                x.reg2 = 1'($urandom); x.rmux = 5'($urandom);
                model_step(k, x, e, ns);
                apply(k, x, e, ns);
            end
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 450; n++) begin
            int k;
            k = $urandom_range(0, 2);
            x = rand_instr();
            model_step(k, x, e, ns);
            apply(k, x, e, ns);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
